proc_program_sequencer: RTL and testbench

- Host-side counterpart of the accumulator processor core.
- Buffers a host-loaded program and replays it word by word onto the core's data input.
- Generates the core's fetch/execute strobes, reset and buffer-enable (y).
- Captures the core's 32-bit data output for flagged words and returns each capture to the host over a valid/ready result channel.

---
 rtl/proc_program_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_proc_program_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_program_sequencer.sv
// ---------------------------------------------------------------------------
// proc_program_sequencer
//
// Host-side companion of the accumulator processor core. The host loads a
// program word by word into a small buffer. On a start request the sequencer
// holds the core in reset for RST_CYC cycles. It then replays each word onto
// the core data input and drives the fetch and execute strobes. For every
// word loaded with its capture bit set, the core output is returned to the
// host over a valid/ready result channel.
//
// Ports
//   execlk      sole clock, rising edge
//   rst         synchronous active-high reset
//   ld_valid    host program-word valid
//   ld_ready    buffer can accept a word (idle and not full)
//   ld_data     program word {opcode[31:28], operand[27:0]}
//   ld_cap      capture core output after this word executes
//   start       one-cycle run request
//   busy        run in progress
//   done        one-cycle pulse at run completion
//   words       number of loaded words
//   proc_data   core data input
//   proc_fetch  core fetch strobe
//   proc_exec   core execute strobe
//   proc_y      core output-buffer enable
//   proc_rst    core reset
//   proc_dout   core data output
//   res_valid   captured result available
//   res_data    captured result
//   res_ready   host accepts result
//   run_cycles  busy-cycle counter, present only with the option below
//
// Option macro: PROC_SEQ_CYCLE_CNT_EN
//   Adds run_cycles[31:0]. It counts the cycles with busy=1 and saturates at
//   all ones. It is cleared on an accepted start and on rst, and it holds
//   after the run finishes.
// ---------------------------------------------------------------------------
module proc_program_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int RST_CYC = 2
) (
  input  logic          execlk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_cap,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   words,
  output logic [31:0]   proc_data,
  output logic          proc_fetch,
  output logic          proc_exec,
  output logic          proc_y,
  output logic          proc_rst,
  input  logic [31:0]   proc_dout,
  output logic          res_valid,
  output logic [31:0]   res_data,
`ifdef PROC_SEQ_CYCLE_CNT_EN
  output logic [31:0]   run_cycles,
`endif
  input  logic          res_ready
);

  localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [CW-1:0] RstLast = CW'(RST_CYC - 1);
  localparam logic [AW:0]   DepthW  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OneW    = (AW+1)'(1);

  typedef enum logic [3:0] {
    IDLE,
    RSTC,
    FETCH,
    EXEC,
    SETTLE,
    CAPT,
    WAITR,
    NEXT,
    FIN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     words_q, words_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [31:0]     pdata_q, pdata_d;
  logic            resValid_q, resValid_d;
  logic [31:0]     resData_q, resData_d;

  logic [31:0]     buf_q [DEPTH];
  logic            cap_q [DEPTH];

  logic            startAcc;
  logic            ldAcc;
  logic            lastWord;

  // A start is honoured only in IDLE with something loaded. It takes
  // priority over a word offered in the same cycle.
  assign startAcc = (state_q == IDLE) && start && (words_q != '0);
  assign ld_ready = (state_q == IDLE) && (words_q < DepthW);
  assign ldAcc    = ld_valid && ld_ready && !startAcc;
  assign lastWord = ({1'b0, ptr_q} == (words_q - OneW));

  // Program buffer storage. Its contents are don't-care after reset, so it
  // carries no reset.
  always_ff @(posedge execlk) begin
    if (ldAcc) begin
      buf_q[words_q[AW-1:0]] <= ld_data;
      cap_q[words_q[AW-1:0]] <= ld_cap;
    end
  end

  // Control state register.
  always_ff @(posedge execlk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      words_q    <= '0;
      rcnt_q     <= '0;
      pdata_q    <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      words_q    <= words_d;
      rcnt_q     <= rcnt_d;
      pdata_q    <= pdata_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
    end
  end

  // Next-state logic. Each word walks FETCH -> EXEC -> SETTLE. It then goes
  // through CAPT -> WAITR when flagged, and ends in NEXT. The core output is
  // sampled on the edge leaving CAPT.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    words_d    = words_q;
    rcnt_d     = rcnt_q;
    pdata_d    = pdata_q;
    resValid_d = resValid_q;
    resData_d  = resData_q;

    case (state_q)
      IDLE: begin
        if (startAcc) begin
          state_d = RSTC;
          ptr_d   = '0;
          rcnt_d  = '0;
        end else if (ldAcc) begin
          words_d = words_q + OneW;
        end
      end
      RSTC: begin
        if (rcnt_q == RstLast) begin
          state_d = FETCH;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
      FETCH: begin
        pdata_d = buf_q[ptr_q];
        state_d = EXEC;
      end
      EXEC: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = cap_q[ptr_q] ? CAPT : NEXT;
      end
      CAPT: begin
        resData_d  = proc_dout;
        resValid_d = 1'b1;
        state_d    = WAITR;
      end
      WAITR: begin
        if (resValid_q && res_ready) begin
          resValid_d = 1'b0;
          state_d    = NEXT;
        end
      end
      NEXT: begin
        if (lastWord) begin
          state_d = FIN;
        end else begin
          ptr_d   = ptr_q + AW'(1);
          state_d = FETCH;
        end
      end
      FIN: begin
        words_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state. proc_data shows the buffer word
  // directly during FETCH. It then holds the copy registered in FETCH
  // until the next fetch.
  assign busy       = (state_q != IDLE) && (state_q != FIN);
  assign done       = (state_q == FIN);
  assign words      = words_q;
  assign proc_data  = (state_q == FETCH) ? buf_q[ptr_q] : pdata_q;
  assign proc_fetch = (state_q == FETCH);
  assign proc_exec  = (state_q == EXEC);
  assign proc_y     = ((state_q == SETTLE) && cap_q[ptr_q]) || (state_q == CAPT);
  assign proc_rst   = (state_q == IDLE) || (state_q == RSTC);
  assign res_valid  = resValid_q;
  assign res_data   = resData_q;

`ifdef PROC_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  // Busy-cycle counter. It saturates instead of wrapping.
  always_ff @(posedge execlk) begin
    if (rst || startAcc) begin
      cyc_q <= '0;
    end else if (busy && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign run_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_proc_program_sequencer.sv
module tb_proc_program_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int RST_CYC = 2;

  logic          execlk;
  logic          rst;
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_cap;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW:0]   words;
  logic [31:0]   proc_data;
  logic          proc_fetch;
  logic          proc_exec;
  logic          proc_y;
  logic          proc_rst;
  logic [31:0]   proc_dout;
  logic          res_valid;
  logic [31:0]   res_data;
  logic          res_ready;
`ifdef PROC_SEQ_CYCLE_CNT_EN
  logic [31:0]   run_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model of the loaded program. For each word it holds the data,
  // the capture flag, the host stall on the result and the core output value.
  logic [31:0] mWords[$];
  bit          mCaps[$];
  int          mStall[$];
  logic [31:0] mDout[$];

  proc_program_sequencer #(.DEPTH(DEPTH), .AW(AW), .RST_CYC(RST_CYC)) dut (
    .execlk     (execlk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_cap     (ld_cap),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .words      (words),
    .proc_data  (proc_data),
    .proc_fetch (proc_fetch),
    .proc_exec  (proc_exec),
    .proc_y     (proc_y),
    .proc_rst   (proc_rst),
    .proc_dout  (proc_dout),
    .res_valid  (res_valid),
    .res_data   (res_data),
`ifdef PROC_SEQ_CYCLE_CNT_EN
    .run_cycles (run_cycles),
`endif
    .res_ready  (res_ready)
  );

  initial execlk = 1'b0;
  always #5 execlk = ~execlk;

  typedef struct {
    logic        rst;
    logic        ldValid;
    logic [31:0] ldData;
    logic        ldCap;
    logic        start;
    logic        expReady;
    logic [AW:0] expWords;
    logic        expBusy;
    logic        expDone;
    logic        expProcRst;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge execlk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ld_ready"}, 32'(ld_ready), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " words"}, 32'(words), 32'd0);
    checkOutput({tag, " proc_data"}, proc_data, 32'd0);
    checkOutput({tag, " proc_fetch"}, 32'(proc_fetch), 32'd0);
    checkOutput({tag, " proc_exec"}, 32'(proc_exec), 32'd0);
    checkOutput({tag, " proc_y"}, 32'(proc_y), 32'd0);
    checkOutput({tag, " proc_rst"}, 32'(proc_rst), 32'd1);
    checkOutput({tag, " res_valid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, " res_data"}, res_data, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    rst      = v.rst;
    ld_valid = v.ldValid;
    ld_data  = v.ldData;
    ld_cap   = v.ldCap;
    start    = v.start;
    tick();
    checkOutput({tag, " ld_ready"}, 32'(ld_ready), 32'(v.expReady));
    checkOutput({tag, " words"}, 32'(words), 32'(v.expWords));
    checkOutput({tag, " busy"}, 32'(busy), 32'(v.expBusy));
    checkOutput({tag, " done"}, 32'(done), 32'(v.expDone));
    checkOutput({tag, " proc_rst"}, 32'(proc_rst), 32'(v.expProcRst));
  endtask

  task automatic loadWord(input logic [31:0] data, input bit cap, input int stall, input logic [31:0] dout);
    bit expAcc;
    expAcc = (mWords.size() < DEPTH);
    checkOutput("load ld_ready", 32'(ld_ready), 32'(expAcc));
    ld_valid = 1'b1;
    ld_data  = data;
    ld_cap   = cap;
    tick();
    ld_valid = 1'b0;
    ld_cap   = 1'b0;
    if (expAcc) begin
      mWords.push_back(data);
      mCaps.push_back(cap);
      mStall.push_back(stall);
      mDout.push_back(dout);
    end
    checkOutput("load words", 32'(words), 32'(mWords.size()));
  endtask

  task automatic clearModel();
    mWords.delete();
    mCaps.delete();
    mStall.delete();
    mDout.delete();
  endtask

  // Follows one run from the cycle after the start edge. Expected latency:
  // RST_CYC reset cycles, 4 cycles per word, and 2 more per captured word
  // plus the host stall on that word's result.
  task automatic monitorRun(input bit midStart);
    int n, expLat, capCnt, fetchIdx, execCnt, resCnt, waitCnt, edges, cur;
    bit gotDone, prevValid;
    logic [31:0] heldRes;
    n = mWords.size();
    expLat = RST_CYC;
    capCnt = 0;
    for (int i = 0; i < n; i++) begin
      expLat += 4;
      if (mCaps[i]) begin
        expLat += 2 + mStall[i];
        capCnt++;
      end
    end
    fetchIdx = 0; execCnt = 0; resCnt = 0; waitCnt = 0; edges = 0;
    gotDone = 1'b0; prevValid = 1'b0; heldRes = '0;
    while (!gotDone && edges < 3000) begin
      tick();
      edges++;
      start = midStart && (edges == 3);
      if (proc_fetch) begin
        if (fetchIdx < n) checkOutput("fetch proc_data", proc_data, mWords[fetchIdx]);
        else checkOutput("extra fetch", 32'(fetchIdx), 32'(n));
        checkOutput("fetch/exec overlap", 32'(proc_exec), 32'd0);
        fetchIdx++;
      end
      if (proc_exec) execCnt++;
      cur = fetchIdx - 1;
      proc_dout = (cur >= 0 && cur < n) ? mDout[cur] : 32'hDEAD_BEEF;
      if (proc_y) begin
        checkOutput("proc_y on flagged word", 32'((cur >= 0 && cur < n) ? mCaps[cur] : 1'b0), 32'd1);
      end
      if (res_valid) begin
        if (!prevValid) begin
          resCnt++;
          checkOutput("res_data", res_data, (cur >= 0 && cur < n) ? mDout[cur] : 32'hDEAD_BEEF);
          heldRes = res_data;
          waitCnt = 0;
        end else begin
          checkOutput("res_data stable", res_data, heldRes);
        end
        if (cur >= 0 && cur < n && waitCnt < mStall[cur]) begin
          res_ready = 1'b0;
          waitCnt++;
        end else begin
          res_ready = 1'b1;
        end
      end else begin
        res_ready = 1'b0;
      end
      prevValid = res_valid;
      if (done) gotDone = 1'b1;
    end
    start = 1'b0;
    res_ready = 1'b0;
    checkOutput("run finished in budget", 32'(gotDone), 32'd1);
    checkOutput("done latency", 32'(edges), 32'(expLat));
    checkOutput("fetch count", 32'(fetchIdx), 32'(n));
    checkOutput("exec count", 32'(execCnt), 32'(n));
    checkOutput("result count", 32'(resCnt), 32'(capCnt));
    checkOutput("busy at done", 32'(busy), 32'd0);
`ifdef PROC_SEQ_CYCLE_CNT_EN
    checkOutput("run_cycles", run_cycles, 32'(expLat));
`endif
    tick();
    checkOutput("done one cycle", 32'(done), 32'd0);
    checkOutput("words cleared", 32'(words), 32'd0);
    checkOutput("ld_ready after run", 32'(ld_ready), 32'd1);
    clearModel();
  endtask

  task automatic startRun(input bit midStart);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start accepted busy", 32'(busy), 32'd1);
    monitorRun(midStart);
  endtask

  initial begin
    int waitCnt, doneSeen;
    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_cap = 1'b0;
    start = 1'b0; proc_dout = '0; res_ready = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    checkResetState("reset");

    // Idle-phase vectors: ignored start, loading, reset clearing words, and
    // start winning over a simultaneous load.
    vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 32'h1111_0001, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 32'h2222_0002, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 32'h3333_0003, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'h4444_0004, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);
    rst = 1'b0; ld_valid = 1'b0; ld_cap = 1'b0; start = 1'b0;
    mWords.push_back(32'h3333_0003); mCaps.push_back(1'b0);
    mStall.push_back(0); mDout.push_back(32'h0);
    monitorRun(1'b0);

    // Three plain words, with a start attempt while busy.
    loadWord(32'h1000_0011, 1'b0, 0, 32'h0);
    loadWord(32'h2000_0022, 1'b0, 0, 32'h0);
    loadWord(32'h3000_0033, 1'b0, 0, 32'h0);
    startRun(1'b1);

    // Full buffer, then a 17th word is refused.
    for (int i = 0; i < DEPTH; i++) loadWord(32'hA000_0000 + 32'(i), 1'b0, 0, 32'h0);
    loadWord(32'hFFFF_FFFF, 1'b0, 0, 32'h0);
    checkOutput("full ld_ready", 32'(ld_ready), 32'd0);
    startRun(1'b0);

    // Capture on the second word, host stalls 5 cycles.
    loadWord(32'h5000_0001, 1'b0, 0, 32'h0);
    loadWord(32'h6000_0002, 1'b1, 5, 32'h0000_00A5);
    loadWord(32'h7000_0003, 1'b0, 0, 32'h0);
    startRun(1'b0);

    // Start with an empty buffer is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty start busy", 32'(busy), 32'd0);
    checkOutput("empty start done", 32'(done), 32'd0);
    tick();
    checkOutput("empty start done later", 32'(done), 32'd0);

    // Reset during the execute cycle of the first word.
    loadWord(32'h8000_0001, 1'b1, 0, 32'h0);
    loadWord(32'h9000_0002, 1'b0, 0, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    waitCnt = 0;
    while (!proc_exec && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    checkOutput("reached exec", 32'(proc_exec), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("rst in exec");
`ifdef PROC_SEQ_CYCLE_CNT_EN
    checkOutput("run_cycles after rst", run_cycles, 32'd0);
`endif
    clearModel();

    // Reset while a result is outstanding drops it, and done never pulses.
    loadWord(32'hB000_0001, 1'b1, 100, 32'h0);
    proc_dout = 32'h1234_5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitCnt = 0;
    while (!res_valid && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    checkOutput("result outstanding", 32'(res_valid), 32'd1);
    checkOutput("outstanding res_data", res_data, 32'h1234_5678);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkResetState("rst in waitr");
    doneSeen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("no done after rst", 32'(doneSeen), 32'd0);
    clearModel();

    // Randomized programs against the model.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        loadWord($urandom(), ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom());
      end
      startRun(bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
